// File: rtl/iv_pair_sequencer.sv
// Launches paired I/V conversions, captures both results atomically and queues them in a 2-entry FIFO.
// Optional WAIT timeout with ERR state is compiled in when IV_PAIR_TIMEOUT_EN is defined.
module iv_pair_sequencer #(
  parameter int unsigned W    = 32,
  parameter int unsigned TO_W = 10
) (
  input  logic         CLK,
  input  logic         RST_PAIR,
  input  logic         START,
  output logic         Begin_FSM_I,
  output logic         Begin_FSM_V,
  input  logic         ACK_I,
  input  logic         ACK_V,
  input  logic [W-1:0] RESULT_I,
  input  logic [W-1:0] RESULT_V,
  output logic         VALID_OUT,
  input  logic         READY_OUT,
  output logic [W-1:0] I_OUT,
  output logic [W-1:0] V_OUT,
  output logic         BUSY,
  output logic         FULL,
  output logic         TIMEOUT_ERR
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_PUSH   = 3'd3,
    S_ERR    = 3'd4
  } state_e;

  state_e         state_q, state_d;
  logic           ack_i_q, ack_v_q;
  logic           got_i_q, got_i_d, got_v_q, got_v_d;
  logic [W-1:0]   pair_i_q, pair_i_d, pair_v_q, pair_v_d;
  logic [W-1:0]   mem_i_q [2];
  logic [W-1:0]   mem_v_q [2];
  logic           wr_ptr_q, rd_ptr_q;
  logic [1:0]     count_q, count_d;
  logic           push_c, pop_c;
  logic           begin_q, begin_d;
  logic           busy_q, busy_d;
  logic           valid_q, valid_d;
  logic           full_q, full_d;
  logic           rise_i_c, rise_v_c;
`ifdef IV_PAIR_TIMEOUT_EN
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
`endif

  assign rise_i_c = ACK_I & ~ack_i_q;
  assign rise_v_c = ACK_V & ~ack_v_q;

  // State register
  always_ff @(posedge CLK or posedge RST_PAIR) begin
    if (RST_PAIR) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next state plus capture of the pending pair
  always_comb begin
    state_d  = state_q;
    got_i_d  = got_i_q;
    got_v_d  = got_v_q;
    pair_i_d = pair_i_q;
    pair_v_d = pair_v_q;
`ifdef IV_PAIR_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (START && (count_q != 2'd2)) state_d = S_LAUNCH;
      end
      S_LAUNCH: begin
        got_i_d = 1'b0;
        got_v_d = 1'b0;
`ifdef IV_PAIR_TIMEOUT_EN
        cnt_d   = '0;
`endif
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (rise_i_c && !got_i_q) begin
          pair_i_d = RESULT_I;
          got_i_d  = 1'b1;
        end
        if (rise_v_c && !got_v_q) begin
          pair_v_d = RESULT_V;
          got_v_d  = 1'b1;
        end
        if (got_i_d && got_v_d) begin
          state_d = S_PUSH;
        end else begin
`ifdef IV_PAIR_TIMEOUT_EN
          if (cnt_q == '1) state_d = S_ERR;
          else             cnt_d   = cnt_q + TO_W'(1);
`endif
        end
      end
      S_PUSH:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO occupancy and next values of the registered outputs
  always_comb begin
    push_c  = (state_q == S_PUSH);
    pop_c   = valid_q & READY_OUT;
    count_d = count_q;
    if (push_c && !pop_c)      count_d = count_q + 2'd1;
    else if (!push_c && pop_c) count_d = count_q - 2'd1;
    begin_d = (state_d == S_LAUNCH);
    busy_d  = (state_d != S_IDLE);
    valid_d = (count_d != 2'd0);
    full_d  = (count_d == 2'd2);
`ifdef IV_PAIR_TIMEOUT_EN
    err_d   = err_q;
    if (state_d == S_LAUNCH)   err_d = 1'b0;
    else if (state_d == S_ERR) err_d = 1'b1;
`endif
  end

  // Datapath, FIFO storage and output registers
  always_ff @(posedge CLK or posedge RST_PAIR) begin
    if (RST_PAIR) begin
      ack_i_q    <= 1'b0;
      ack_v_q    <= 1'b0;
      got_i_q    <= 1'b0;
      got_v_q    <= 1'b0;
      pair_i_q   <= '0;
      pair_v_q   <= '0;
      mem_i_q[0] <= '0;
      mem_i_q[1] <= '0;
      mem_v_q[0] <= '0;
      mem_v_q[1] <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      begin_q    <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      full_q     <= 1'b0;
`ifdef IV_PAIR_TIMEOUT_EN
      cnt_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      ack_i_q  <= ACK_I;
      ack_v_q  <= ACK_V;
      got_i_q  <= got_i_d;
      got_v_q  <= got_v_d;
      pair_i_q <= pair_i_d;
      pair_v_q <= pair_v_d;
      if (push_c) begin
        mem_i_q[wr_ptr_q] <= pair_i_q;
        mem_v_q[wr_ptr_q] <= pair_v_q;
        wr_ptr_q          <= ~wr_ptr_q;
      end
      if (pop_c) rd_ptr_q <= ~rd_ptr_q;
      count_q  <= count_d;
      begin_q  <= begin_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      full_q   <= full_d;
`ifdef IV_PAIR_TIMEOUT_EN
      cnt_q    <= cnt_d;
      err_q    <= err_d;
`endif
    end
  end

  assign Begin_FSM_I = begin_q;
  assign Begin_FSM_V = begin_q;
  assign BUSY        = busy_q;
  assign VALID_OUT   = valid_q;
  assign FULL        = full_q;
  assign I_OUT       = mem_i_q[rd_ptr_q];
  assign V_OUT       = mem_v_q[rd_ptr_q];
`ifdef IV_PAIR_TIMEOUT_EN
  assign TIMEOUT_ERR = err_q;
`else
  assign TIMEOUT_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_iv_pair_sequencer.sv
// Scoreboard bench for iv_pair_sequencer: directed scenarios plus randomized pairs with random consumer stalls.
module tb_iv_pair_sequencer;
  localparam int unsigned W = 32;

  logic         CLK = 1'b0;
  logic         RST_PAIR, START, ACK_I, ACK_V, READY_OUT;
  logic [W-1:0] RESULT_I, RESULT_V;
  logic         Begin_FSM_I, Begin_FSM_V, VALID_OUT, BUSY, FULL, TIMEOUT_ERR;
  logic [W-1:0] I_OUT, V_OUT;

  typedef struct packed {
    logic [W-1:0] i;
    logic [W-1:0] v;
  } pair_t;

  pair_t exp_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  bit    rand_ready = 1'b0;

  iv_pair_sequencer #(.W(W), .TO_W(4)) dut (
    .CLK(CLK), .RST_PAIR(RST_PAIR), .START(START),
    .Begin_FSM_I(Begin_FSM_I), .Begin_FSM_V(Begin_FSM_V),
    .ACK_I(ACK_I), .ACK_V(ACK_V), .RESULT_I(RESULT_I), .RESULT_V(RESULT_V),
    .VALID_OUT(VALID_OUT), .READY_OUT(READY_OUT), .I_OUT(I_OUT), .V_OUT(V_OUT),
    .BUSY(BUSY), .FULL(FULL), .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  // Monitor: every handshake pops the oldest expected pair
  always @(negedge CLK) begin
    pair_t e;
    if (!RST_PAIR && VALID_OUT && READY_OUT) begin
      if (exp_q.size() == 0) begin
        check("pop_unexpected", 64'(1), 64'(0));
      end else begin
        e = exp_q.pop_front();
        check("pop_i", 64'(I_OUT), 64'(e.i));
        check("pop_v", 64'(V_OUT), 64'(e.v));
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
    if (rand_ready) READY_OUT = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_start_ok();
    int b = 0;
    while ((BUSY || FULL) && b < 300) begin
      tick();
      b++;
    end
    check("wait_idle_bound", 64'(b < 300), 64'(1));
  endtask

  // One full transaction; returns in the PUSH cycle with both ACKs dropped
  task automatic do_pair(input logic [W-1:0] iv, input logic [W-1:0] vv,
                         input int di, input int dv, input bit glitch);
    int last;
    START = 1'b1;
    tick();
    START = 1'b0;
    check("begin_i_launch", 64'(Begin_FSM_I), 64'(1));
    check("begin_v_launch", 64'(Begin_FSM_V), 64'(1));
    check("err_clear_launch", 64'(TIMEOUT_ERR), 64'(0));
    check("busy_launch", 64'(BUSY), 64'(1));
    tick();
    check("begin_one_cycle", 64'({Begin_FSM_I, Begin_FSM_V}), 64'(0));
    last = (di > dv) ? di : dv;
    if (glitch && (dv + 4 > last)) last = dv + 4;
    for (int k = 0; k <= last; k++) begin
      ACK_I    = (k >= di);
      RESULT_I = (k >= di) ? iv : W'($urandom);
      if (glitch) begin
        ACK_V    = ((k >= dv) && (k < dv + 2)) || (k >= dv + 4);
        RESULT_V = (k < dv + 4) ? vv : ~vv;
      end else begin
        ACK_V    = (k >= dv);
        RESULT_V = (k >= dv) ? vv : W'($urandom);
      end
      tick();
    end
    check("busy_push", 64'(BUSY), 64'(1));
    ACK_I = 1'b0;
    ACK_V = 1'b0;
    exp_q.push_back('{i: iv, v: vv});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int b;
    RST_PAIR = 1'b1; START = 1'b0; ACK_I = 1'b0; ACK_V = 1'b0; READY_OUT = 1'b0;
    RESULT_I = '0; RESULT_V = '0;
    repeat (3) tick();
    check("rst_begin", 64'({Begin_FSM_I, Begin_FSM_V}), 64'(0));
    check("rst_valid", 64'(VALID_OUT), 64'(0));
    check("rst_i_out", 64'(I_OUT), 64'(0));
    check("rst_v_out", 64'(V_OUT), 64'(0));
    check("rst_busy_full_err", 64'({BUSY, FULL, TIMEOUT_ERR}), 64'(0));
    RST_PAIR = 1'b0;
    tick();

    // Basic pair, VALID latency two cycles after the ACK edge
    do_pair(32'h0001_8000, 32'h00C8_0000, 2, 2, 1'b0);
    check("valid_in_push", 64'(VALID_OUT), 64'(0));
    tick();
    check("valid_after_push", 64'(VALID_OUT), 64'(1));
    check("head_i", 64'(I_OUT), 64'(32'h0001_8000));
    check("head_v", 64'(V_OUT), 64'(32'h00C8_0000));
    check("busy_idle", 64'(BUSY), 64'(0));
    READY_OUT = 1'b1;
    tick();
    READY_OUT = 1'b0;
    check("empty_after_pop", 64'(VALID_OUT), 64'(0));

    // V early with a re-rise carrying a different value; first V kept
    do_pair(32'h1234_5678, 32'hCAFE_0001, 10, 0, 1'b1);
    tick();
    READY_OUT = 1'b1;
    tick();
    READY_OUT = 1'b0;

    // Fill FIFO, third START ignored, then drain in order
    do_pair(32'hA000_0001, 32'hA000_0002, 1, 3, 1'b0);
    tick();
    do_pair(32'hB000_0001, 32'hB000_0002, 4, 0, 1'b0);
    tick();
    check("full_two", 64'(FULL), 64'(1));
    START = 1'b1;
    tick();
    START = 1'b0;
    check("full_no_begin", 64'({Begin_FSM_I, Begin_FSM_V}), 64'(0));
    check("full_no_busy", 64'(BUSY), 64'(0));
    tick();
    check("full_still_idle", 64'({BUSY, FULL}), 64'(2'b01));
    READY_OUT = 1'b1;
    tick();
    check("full_clear_first_pop", 64'({FULL, VALID_OUT}), 64'(2'b01));
    tick();
    READY_OUT = 1'b0;
    check("empty_after_two_pops", 64'(VALID_OUT), 64'(0));

    // Push and pop in the same cycle with one entry present
    do_pair(32'hC000_0001, 32'hC000_0002, 0, 0, 1'b0);
    tick();
    do_pair(32'hD000_0001, 32'hD000_0002, 2, 1, 1'b0);
    READY_OUT = 1'b1;
    tick();
    READY_OUT = 1'b0;
    check("pushpop_count_one", 64'({VALID_OUT, FULL}), 64'(2'b10));
    READY_OUT = 1'b1;
    tick();
    READY_OUT = 1'b0;
    check("pushpop_drained", 64'(VALID_OUT), 64'(0));

`ifdef IV_PAIR_TIMEOUT_EN
    // Only ACK_I arrives: ERR after the counter saturates at 15
    START = 1'b1;
    tick();
    START = 1'b0;
    tick();
    ACK_I = 1'b1;
    RESULT_I = 32'h5555_AAAA;
    for (int n = 1; n <= 16; n++) begin
      tick();
      if (n == 15) check("to_not_yet", 64'(TIMEOUT_ERR), 64'(0));
    end
    check("to_err_set", 64'(TIMEOUT_ERR), 64'(1));
    check("to_fifo_unchanged", 64'(VALID_OUT), 64'(0));
    ACK_I = 1'b0;
    tick();
    check("to_err_sticky_idle", 64'({TIMEOUT_ERR, BUSY}), 64'(2'b10));
    tick();
    do_pair(32'hE000_0001, 32'hE000_0002, 1, 1, 1'b0);
    tick();
    READY_OUT = 1'b1;
    tick();
    READY_OUT = 1'b0;
`endif

    // Reset during WAIT after ACK_I captured, then a late ACK_V
    START = 1'b1;
    tick();
    START = 1'b0;
    tick();
    ACK_I = 1'b1;
    RESULT_I = 32'h0BAD_0BAD;
    tick();
    tick();
    RST_PAIR = 1'b1;
    #1;
    check("midrst_outputs", 64'({Begin_FSM_I, Begin_FSM_V, VALID_OUT, BUSY, FULL, TIMEOUT_ERR}), 64'(0));
    check("midrst_data", 64'({I_OUT, V_OUT}), 64'(0));
    ACK_I = 1'b0;
    tick();
    RST_PAIR = 1'b0;
    ACK_V = 1'b1;
    RESULT_V = 32'h0BAD_0BAD;
    tick();
    tick();
    ACK_V = 1'b0;
    repeat (3) tick();
    check("midrst_no_push", 64'({VALID_OUT, BUSY, FULL}), 64'(0));

    // Randomized pairs with random consumer stalls
    rand_ready = 1'b1;
    for (int t = 0; t < 25; t++) begin
      wait_start_ok();
      do_pair(W'($urandom), W'($urandom), int'($urandom_range(0, 6)), int'($urandom_range(0, 6)), 1'b0);
    end
    rand_ready = 1'b0;
    READY_OUT = 1'b1;
    b = 0;
    while ((exp_q.size() != 0) && b < 200) begin
      tick();
      b++;
    end
    READY_OUT = 1'b0;
    tick();
    check("drain_queue_empty", 64'(exp_q.size()), 64'(0));
    check("drain_valid_low", 64'(VALID_OUT), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/iv_pair_sequencer.md
# iv_pair_sequencer

Sequencer and pairing buffer placed directly downstream of the current/voltage linearizer-normalizer stage. On request it launches both conversions (current path and voltage path), waits for both completion acknowledges, and captures the two 32-bit fixed-point results as one atomic pair. Completed pairs go into a 2-entry FIFO, which the estimator core drains through a valid/ready handshake.

## Interface
- W, 32, width of each fixed-point sample (RESULT_I / RESULT_V)
- TO_W, 10, width of the WAIT timeout counter; timeout fires at 2^TO_W−1 cycles
- CLK  in  1  system clock, rising edge
- RST_PAIR  in  1  asynchronous, active-high reset
- START  in  1  request one new I/V pair; sampled only in IDLE
- Begin_FSM_I  out  1  one-cycle launch pulse to current path
- Begin_FSM_V  out  1  one-cycle launch pulse to voltage path
- ACK_I  in  1  current conversion done (level)
- ACK_V  in  1  voltage conversion done (level)
- RESULT_I  in  W  current result, valid while ACK_I high
- RESULT_V  in  W  voltage result, valid while ACK_V high
- VALID_OUT  out  1  FIFO head holds a pair
- READY_OUT  in  1  consumer accepts head pair
- I_OUT  out  W  head pair, current
- V_OUT  out  W  head pair, voltage
- BUSY  out  1  FSM not in IDLE
- FULL  out  1  FIFO holds 2 pairs
- TIMEOUT_ERR  out  1  sticky: WAIT exceeded timeout

## Operation
- FSM states: IDLE, LAUNCH, WAIT, PUSH, ERR.
- IDLE:
  - START=1 and FIFO count<2 → LAUNCH.
  - START while count==2 is ignored; no latching, no pending request.
- LAUNCH:
  - Begin_FSM_I=Begin_FSM_V=1 for exactly this cycle.
  - Clears got_i, got_v and the timeout counter.
  - Clears TIMEOUT_ERR.
  - Next state: WAIT.
- WAIT:
  - Edge detection uses registered ack_i_q / ack_v_q, which are updated every cycle in every state.
  - A rising edge (ACK & ~ack_q) captures the matching RESULT into the pair register and sets got_x.
  - A second edge on an already-captured side is ignored.
  - Edges on both sides in the same cycle capture both.
  - Next state:
    - got_i & got_v (including flags set this cycle) → PUSH.
    - Otherwise the timeout counter increments.
- PUSH:
  - Writes the pair into the FIFO tail; count increments unless a pop happens in the same cycle.
  - Next state: IDLE.
- ERR:
  - Partial captures are discarded; nothing is pushed.
  - Next state: IDLE.
- ACK edges outside WAIT are ignored. ACK must return low between conversions; a level held high never recaptures.
- FIFO:
  - 2 entries, circular, 1-bit read/write pointers plus a 2-bit count.
  - Pop occurs when VALID_OUT & READY_OUT.
  - Push and pop in the same cycle: count unchanged, data order preserved.
  - Push cannot occur at count==2, because LAUNCH is gated on count<2 and the FSM is the only producer.
  - I_OUT/V_OUT show the head entry combinationally from the FIFO registers. Their value is don't-care while VALID_OUT=0.
- Reset mid-operation: FSM → IDLE, FIFO emptied, captured halves dropped. An ACK arriving after reset is ignored (not in WAIT).

## Timing
- Reset values: Begin_FSM_I=0, Begin_FSM_V=0, VALID_OUT=0, I_OUT=0, V_OUT=0, BUSY=0, FULL=0, TIMEOUT_ERR=0. ack_q registers=0, count=0, pointers=0.
- START high at edge n (IDLE) → Begins high during cycle n+1 → WAIT from n+2.
- Last ACK rising edge sampled at edge m → PUSH during m+1 → VALID_OUT=1 from m+2, when the FIFO was empty.
- Minimum START-to-VALID_OUT latency: 4 cycles, with both ACKs rising in the first WAIT cycle.
- Consecutive START requests: the next START is accepted no earlier than the IDLE cycle following PUSH.
- BUSY is high in LAUNCH, WAIT, PUSH and ERR.
- FULL equals (count==2) and is registered.

## Configuration
- IV_PAIR_TIMEOUT_EN defined:
  - Timeout counter is compiled in.
  - WAIT with counter == 2^TO_W−1 and the pair incomplete → ERR. TIMEOUT_ERR is set and stays 1 until the next LAUNCH or reset.
- Undefined:
  - No counter and no ERR state.
  - WAIT persists until both ACKs arrive.
  - TIMEOUT_ERR is tied to 0.

## Test plan
- Reset, START=1 for one cycle; ACK_I and ACK_V rise together 3 cycles after Begin with RESULT_I=0x0001_8000 and RESULT_V=0x00C8_0000 → Begin pulses exactly 1 cycle; VALID_OUT rises 2 cycles after the ACK edge with I_OUT=0x0001_8000 and V_OUT=0x00C8_0000.
- ACK_V rises 10 cycles before ACK_I; ACK_V drops and re-rises with a different RESULT_V → the first V value is kept, and the pair is pushed only after ACK_I.
- READY_OUT=0, run two pairs (A, B), then a third START → FULL=1, the third START gives no Begin pulse, BUSY stays 0. Raise READY_OUT for 2 cycles → A, then B, popped in order; FULL=0 after the first pop.
- Count=1 with READY_OUT=1 while PUSH occurs → count stays 1 and the new pair becomes head after the old one pops.
- IV_PAIR_TIMEOUT_EN defined, TO_W=4, only ACK_I arrives → ERR after 15 WAIT cycles; TIMEOUT_ERR=1 and the FIFO is unchanged. The next START clears TIMEOUT_ERR in its LAUNCH cycle.
- Assert RST_PAIR during WAIT after ACK_I captured, release, then pulse ACK_V → all outputs at reset values, no push, BUSY=0.
